// File: rtl/aes128_key_sched_pkg.sv
// Shared definitions for the AES-128 key-expansion engine: FSM encoding,
// round-constant table and the last-round index.
package aes128_key_sched_pkg;

    localparam int ROUND_LAST = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_SUB  = 2'd2,
        ST_MIX  = 2'd3
    } state_t;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant applied when leaving round idx; out-of-range yields 0.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx < 4'(ROUND_LAST)) begin
            r = RCON[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_key_sched_sbox.sv
// Combinational AES forward S-box: GF(2^8) multiplicative inverse followed
// by the FIPS-197 affine transform.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] AFFINE_C = 8'h63;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8]
                 ^ a[(i + 7) % 8] ^ AFFINE_C[i];
        end
        return b;
    endfunction

    always_comb begin
        out_byte = affine(gf_inv(in_byte));
    end

endmodule

// File: rtl/aes128_key_sched.sv
// Iterative AES-128 key expansion: emits round keys 0..10 over valid/ready,
// computing SubWord byte-serially through a single shared S-box.
module aes128_key_sched
    import aes128_key_sched_pkg::*;
#(
    parameter int NROUNDS = ROUND_LAST
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         abort,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);

    state_t       state_q, state_d;
    logic [127:0] w_q, w_d;
    logic [31:0]  temp_q, temp_d;
    logic [3:0]   idx_q, idx_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out;
    logic [31:0]  w3;
    logic [31:0]  t;
    logic [31:0]  nw0, nw1, nw2, nw3;

    aes_sbox u_sbox (
        .in_byte  (sbox_in),
        .out_byte (sbox_out)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        temp_d  = temp_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        // RotWord folded into the byte selection order.
        w3 = w_q[31:0];
        case (cnt_q)
            2'd0:    sbox_in = w3[23:16];
            2'd1:    sbox_in = w3[15:8];
            2'd2:    sbox_in = w3[7:0];
            default: sbox_in = w3[31:24];
        endcase

        t   = temp_q ^ {rcon_of(idx_q), 24'h000000};
        nw0 = w_q[127:96] ^ t;
        nw1 = w_q[95:64]  ^ nw0;
        nw2 = w_q[63:32]  ^ nw1;
        nw3 = w_q[31:0]   ^ nw2;

        if (abort) begin
            state_d = ST_IDLE;
            w_d     = '0;
            temp_d  = '0;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        w_d     = key;
                        idx_d   = 4'd0;
                        state_d = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready) begin
                        if (idx_q == 4'(NROUNDS)) begin
                            // Final key accepted: leave no key material behind.
                            state_d = ST_IDLE;
                            w_d     = '0;
                            temp_d  = '0;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_SUB;
                            cnt_d   = 2'd0;
                        end
                    end
                end
                ST_SUB: begin
                    case (cnt_q)
                        2'd0:    temp_d[31:24] = sbox_out;
                        2'd1:    temp_d[23:16] = sbox_out;
                        2'd2:    temp_d[15:8]  = sbox_out;
                        default: temp_d[7:0]   = sbox_out;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_MIX;
                    end
                end
                default: begin
                    w_d     = {nw0, nw1, nw2, nw3};
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_EMIT;
                end
            endcase
        end

        rk_valid_d = (state_d == ST_EMIT);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            w_q        <= '0;
            temp_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            temp_q     <= temp_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rk       = w_q;
    assign rk_idx   = idx_q;
    assign rk_valid = rk_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes128_key_sched.sv
// Scoreboard bench for aes128_key_sched: a word-level FIPS-197 key expansion
// model queues expected round keys; a negedge monitor checks what the DUT emits.
module tb_aes128_key_sched;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [127:0] key;
    logic         abort;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;

    aes128_key_sched dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .key      (key),
        .abort    (abort),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int hs_count = 0;
    int hs_cyc [11];
    logic [127:0] got_rk [11];
    logic [131:0] sb_q [$];
    logic [7:0]   sbox_t [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ a;
            a = xtime(a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] xb;
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_expect(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tw;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tw = w[i - 1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sbox_t[tw[31:24]], sbox_t[tw[23:16]], sbox_t[tw[15:8]], sbox_t[tw[7:0]]};
                tw = tw ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i - 4] ^ tw;
        end
        for (int r = 0; r < 11; r++) begin
            sb_q.push_back({4'(r), w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]});
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (resetn && rk_valid) begin
            chk("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
            if (sb_q.size() != 0) begin
                chk("rk", rk, sb_q[0][127:0]);
                chk("rk_idx", 128'(rk_idx), 128'(sb_q[0][131:128]));
                if (rk_ready && !abort) begin
                    got_rk[rk_idx] = rk;
                    hs_cyc[rk_idx] = cyc;
                    hs_count++;
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k);
        key       = k;
        start     = 1'b1;
        start_cyc = cyc;
        hs_count  = 0;
        build_expect(k);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_round(input int k);
        bit found;
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (rk_valid && rk_idx == 4'(k)) found = 1;
        end
        chk("wait_round_timeout", 128'(found), 128'(1));
    endtask

    task automatic wait_done(input bit rand_ready);
        bit got;
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (rand_ready) rk_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) got = 1;
        end
        done_cyc = cyc;
        rk_ready = 1'b1;
        chk("done_timeout", 128'(got), 128'(1));
        chk("rk_zeroized", rk, 128'h0);
        chk("hs_count", 128'(hs_count), 128'(11));
        chk("sb_drained", 128'(sb_q.size()), 128'(0));
        tick();
        chk("done_width", 128'(done), 128'(0));
    endtask

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        rk_ready = 1'b1;
        key      = '0;
        build_sbox();
        #1;
        chk("rst_rk", rk, 128'h0);
        chk("rst_ctl", 128'({rk_valid, busy, done, rk_idx}), 128'(0));
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // FIPS-197 A.1 with ready tied high
        do_start(KEY_A);
        wait_done(0);
        chk("a1_rk0", got_rk[0], KEY_A);
        chk("a1_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("a1_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("a1_t_rk0", 128'(hs_cyc[0] - start_cyc), 128'(1));
        chk("a1_t_rk10", 128'(hs_cyc[10] - start_cyc), 128'(61));
        chk("a1_t_done", 128'(done_cyc - start_cyc), 128'(62));
        chk("a1_idle", 128'(busy), 128'(0));

        // back-pressure on round 3
        do_start(KEY_A);
        wait_round(3);
        rk_ready = 1'b0;
        repeat (20) tick();
        chk("bp_hold_rk", rk, 128'h3d80477d4716fe3e1e237e446d7a883b);
        chk("bp_hold_idx", 128'(rk_idx), 128'(3));
        rk_ready = 1'b1;
        wait_done(0);
        chk("bp_spacing", 128'(hs_cyc[4] - hs_cyc[3]), 128'(6));

        // start while busy is ignored
        do_start(KEY_A);
        wait_round(5);
        key   = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", 128'(busy), 128'(1));
        wait_done(0);
        chk("ign_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // abort coincident with round-4 handshake
        begin
            bit saw_done;
            logic [127:0] k2;
            do_start(KEY_A);
            wait_round(4);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_rk", rk, 128'h0);
            chk("abort_ctl", 128'({rk_valid, busy, rk_idx}), 128'(0));
            sb_q.delete();
            saw_done = 0;
            repeat (10) begin
                if (done) saw_done = 1;
                tick();
            end
            chk("abort_no_done", 128'(saw_done), 128'(0));
            k2 = {$urandom, $urandom, $urandom, $urandom};
            do_start(k2);
            wait_done(0);
            chk("abort_restart_rk0", got_rk[0], k2);
        end

        // start and abort together in IDLE: abort wins
        key   = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 128'({rk_valid, busy}), 128'(0));

        // async reset during SUB of round 7
        do_start(KEY_A);
        wait_round(7);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        chk("mid_rst_rk", rk, 128'h0);
        chk("mid_rst_ctl", 128'({rk_valid, busy, done, rk_idx}), 128'(0));
        sb_q.delete();
        tick();
        resetn = 1'b1;
        tick();
        do_start(128'h000102030405060708090a0b0c0d0e0f);
        wait_done(0);
        chk("c1_rk10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // all-zero key
        do_start(128'h0);
        wait_done(0);
        chk("zero_rk1", got_rk[1], 128'h62636363626363636263636362636363);

        // random keys under random back-pressure
        for (int n = 0; n < 4; n++) begin
            do_start({$urandom, $urandom, $urandom, $urandom});
            wait_done(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes128_key_sched.md
Name: aes128_key_sched

Overview:
- Iterative AES-128 key-expansion engine for the crypto_trng conditioning path.
- Turns a 128-bit seed key into the 11 round keys (rounds 0..10) and streams them out one at a time over a valid/ready handshake.
- Time-multiplexes a single aes_sbox instance byte-serially for SubWord, so it is the direct upstream driver and consumer of that S-box.

Parameters:
- NROUNDS, 10, index of the last round key; fixed at 10 for AES-128 and not tunable.

Ports:
- clk  input  1  block clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; samples key; ignored unless idle.
- key  input  128  cipher key; byte 0 is bits [127:120] (FIPS-197 order).
- abort  input  1  synchronous abandon; returns to IDLE and clears state.
- rk_valid  output  1  round key on rk is valid.
- rk_ready  input  1  consumer accepts rk this cycle.
- rk  output  128  current round key (w0..w3, w0 in [127:96]).
- rk_idx  output  4  round number of rk, 0..10.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after round 10 is accepted.

Behaviour:
- Reset (async, resetn=0): state=IDLE. rk, rk_idx, rk_valid, busy, done, the temp word and the byte counter all clear to 0.
- States: IDLE, EMIT, SUB, MIX.
- IDLE:
  - start=1: load key into w0..w3, rk_idx=0, go to EMIT.
  - rk_valid rises the cycle after start (1-cycle latency).
- EMIT:
  - rk_valid=1; rk and rk_idx are held stable until the handshake (rk_valid & rk_ready).
  - Handshake with rk_idx<10: go to SUB with byte counter=0.
  - Handshake with rk_idx=10: go to IDLE, pulse done for exactly 1 cycle, and zeroize rk and temp.
- SUB (4 cycles, counter 0..3):
  - S-box input = byte counter of RotWord(w3), i.e. bytes w3[23:16], w3[15:8], w3[7:0], w3[31:24] in turn.
  - S-box output is registered into temp byte counter.
  - Counter reaching 3 advances to MIX.
- MIX (1 cycle):
  - t = temp ^ {rcon[rk_idx],24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - rk_idx increments; go to EMIT.
- rcon for rk_idx 0..9 (the round being left): 01,02,04,08,10,20,40,80,1b,36. All arithmetic is 8-bit XOR; no carries.
- Round spacing:
  - rk_valid is low in SUB and MIX.
  - The next rk_valid rises 6 cycles after each handshake cycle.
  - With rk_ready tied high, round k is valid at T+1+6k (T = start cycle), and done is asserted at T+62.
- Back-pressure: rk_ready low holds EMIT indefinitely with no change to rk or rk_idx.
- start while busy is ignored; no queuing.
- abort:
  - Takes priority over every other event in the same cycle, including a handshake.
  - Next cycle: IDLE, rk=0, rk_idx=0, rk_valid=0, no done pulse.
  - abort in IDLE is a no-op.
- start and abort in the same cycle in IDLE: abort wins and the start is dropped.
- resetn deasserted mid-operation: immediate clear as above. The consumer must discard any partially received schedule.
- Key material remains only in rk/w registers between start and done/abort; nothing is retained after either.

Decomposition:
- Shared package/include: state encodings, the rcon table as a 10-entry localparam constant, and the ROUND_LAST=10 constant.
- Sub-module: exactly one aes_sbox instance (the existing combinational S-box), driven from the byte mux. No other sub-modules.

Test Plan:
- FIPS-197 A.1 with rk_ready=1, key=2b7e151628aed2a6abf7158809cf4f3c:
  - rk_idx0 = key.
  - rk_idx1 = a0fafe1788542cb123a339392a6c7605.
  - rk_idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+61.
  - done at T+62, exactly 11 handshakes.
- Back-pressure on the same key: rk_ready low for 20 cycles on round 3 → rk stays 3d80477d4716fe3e1e237e446d7a883b; round 4 arrives 6 cycles after release.
- start pulsed again during round 5 → ignored; sequence and round values unchanged; busy stays 1.
- abort asserted in the same cycle as the round-4 handshake → next cycle IDLE, rk=0, rk_valid=0, no done. A new start then reproduces round 0 = new key.
- resetn dropped during SUB of round 7 → all outputs 0 asynchronously. After release, a fresh start with key=000102030405060708090a0b0c0d0e0f gives rk_idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- All-zero key → rk_idx1 = 62636363626363636263636362636363; done pulse width exactly 1 cycle.
